// File: rtl/writeback_bypass_unit_if.sv
// Decode/pipeline-side bundle for the writeback and bypass unit: source queries,
// EX-stage writer info, data RAM read data, and the bypass/stall/register-file answers.
interface writeback_bypass_unit_if #(
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
);
  logic [REG_W-1:0]  forward_rs;
  logic [REG_W-1:0]  forward_rt;
  logic              ex_wen;
  logic [REG_W-1:0]  ex_dest;
  logic              ex_is_load;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;
  logic              rs_fwd;
  logic [DATA_W-1:0] rs_fwd_data;
  logic              rt_fwd;
  logic [DATA_W-1:0] rt_fwd_data;
  logic              rf_we;
  logic [REG_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [31:0]       stall_count;

  modport master (
    output forward_rs, forward_rt, ex_wen, ex_dest, ex_is_load, ex_result, mem_rdata,
    input  stall, rs_fwd, rs_fwd_data, rt_fwd, rt_fwd_data,
    input  rf_we, rf_waddr, rf_wdata, stall_count
  );

  modport slave (
    input  forward_rs, forward_rt, ex_wen, ex_dest, ex_is_load, ex_result, mem_rdata,
    output stall, rs_fwd, rs_fwd_data, rt_fwd, rt_fwd_data,
    output rf_we, rf_waddr, rf_wdata, stall_count
  );
endinterface

// File: rtl/writeback_bypass_unit.sv
// Tracks EX/MEM/WB writers of the 5-stage core, performs the WB register-file write,
// and answers decode's rs/rt queries with bypass data or a load-use stall.
module writeback_bypass_unit #(
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  writeback_bypass_unit_if.slave bus
);

  typedef struct packed {
    logic              hit;
    logic              stl;
    logic [DATA_W-1:0] data;
  } byp_t;

  logic              mem_wen_q, mem_wen_d;
  logic [REG_W-1:0]  mem_dest_q, mem_dest_d;
  logic              mem_load_q, mem_load_d;
  logic [DATA_W-1:0] mem_val_q, mem_val_d;
  logic              wb_wen_q, wb_wen_d;
  logic [REG_W-1:0]  wb_dest_q, wb_dest_d;
  logic [DATA_W-1:0] wb_val_q, wb_val_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  logic [DATA_W-1:0] mem_data;
  byp_t              rs_b, rt_b;
  logic              rs_hit, rt_hit;

  // Youngest writer wins; an EX load hit blocks older slots and asks for a stall.
  function automatic byp_t resolve(
    input logic [REG_W-1:0]  q,
    input logic              e_wen,
    input logic [REG_W-1:0]  e_dest,
    input logic              e_ld,
    input logic [DATA_W-1:0] e_res,
    input logic              m_wen,
    input logic [REG_W-1:0]  m_dest,
    input logic [DATA_W-1:0] m_data,
    input logic              w_wen,
    input logic [REG_W-1:0]  w_dest,
    input logic [DATA_W-1:0] w_val
  );
    byp_t r;
    r = '0;
    if (q != '0) begin
      if (e_wen && e_dest == q) begin
        r.stl  = e_ld;
        r.hit  = !e_ld;
        r.data = e_ld ? '0 : e_res;
      end else if (m_wen && m_dest == q) begin
        r.hit  = 1'b1;
        r.data = m_data;
      end else if (w_wen && w_dest == q) begin
        r.hit  = 1'b1;
        r.data = w_val;
      end
    end
    return r;
  endfunction

  assign mem_data = mem_load_q ? bus.mem_rdata : mem_val_q;

  always_comb begin
    mem_wen_d   = bus.ex_wen;
    mem_dest_d  = bus.ex_dest;
    mem_load_d  = bus.ex_is_load;
    mem_val_d   = bus.ex_result;
    wb_wen_d    = mem_wen_q;
    wb_dest_d   = mem_dest_q;
    wb_val_d    = mem_data;
    stall_cnt_d = stall_cnt_q + {31'b0, bus.stall};
    rs_b = resolve(bus.forward_rs, bus.ex_wen, bus.ex_dest, bus.ex_is_load, bus.ex_result,
                   mem_wen_q, mem_dest_q, mem_data, wb_wen_q, wb_dest_q, wb_val_q);
    rt_b = resolve(bus.forward_rt, bus.ex_wen, bus.ex_dest, bus.ex_is_load, bus.ex_result,
                   mem_wen_q, mem_dest_q, mem_data, wb_wen_q, wb_dest_q, wb_val_q);
  end

  // Answers are held at zero in reset since decode's own outputs are unreset.
  assign rs_hit          = resetn & rs_b.hit;
  assign rt_hit          = resetn & rt_b.hit;
  assign bus.stall       = resetn & (rs_b.stl | rt_b.stl);
  assign bus.rs_fwd      = rs_hit;
  assign bus.rs_fwd_data = rs_hit ? rs_b.data : '0;
  assign bus.rt_fwd      = rt_hit;
  assign bus.rt_fwd_data = rt_hit ? rt_b.data : '0;

  assign bus.rf_we       = resetn & wb_wen_q & (wb_dest_q != '0);
  assign bus.rf_waddr    = resetn ? wb_dest_q : '0;
  assign bus.rf_wdata    = resetn ? wb_val_q : '0;
  assign bus.stall_count = stall_cnt_q;

  // EX -> MEM -> WB shift; no enable, bubbles arrive as ex_wen=0
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_wen_q   <= 1'b0;
      mem_dest_q  <= '0;
      mem_load_q  <= 1'b0;
      mem_val_q   <= '0;
      wb_wen_q    <= 1'b0;
      wb_dest_q   <= '0;
      wb_val_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      mem_wen_q   <= mem_wen_d;
      mem_dest_q  <= mem_dest_d;
      mem_load_q  <= mem_load_d;
      mem_val_q   <= mem_val_d;
      wb_wen_q    <= wb_wen_d;
      wb_dest_q   <= wb_dest_d;
      wb_val_q    <= wb_val_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_writeback_bypass_unit.sv
// Bench for writeback_bypass_unit: per-cycle bypass/stall checks against constants and
// a scoreboard of expected register-file writes released two cycles after EX.
module tb_writeback_bypass_unit;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ld;
  } rf_exp_t;

  logic clk;
  logic resetn;
  int   vec;
  int   errs;
  int   exp_cnt;
  rf_exp_t sb[$];

  writeback_bypass_unit_if bus ();

  writeback_bypass_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic wen, input logic [4:0] dest, input logic ld,
                       input logic [31:0] res, input logic [31:0] rdata,
                       input logic [4:0] rs, input logic [4:0] rt);
    bus.ex_wen     = wen;
    bus.ex_dest    = dest;
    bus.ex_is_load = ld;
    bus.ex_result  = res;
    bus.mem_rdata  = rdata;
    bus.forward_rs = rs;
    bus.forward_rt = rt;
  endtask

  // One pipeline cycle: drive, check combinational answers, clock, check the WB write.
  task automatic tick(input string nm, input logic wen, input logic [4:0] dest,
                      input logic ld, input logic [31:0] res, input logic [31:0] rdata,
                      input logic [4:0] rs, input logic [4:0] rt, input logic es,
                      input logic erf, input logic [31:0] erd,
                      input logic etf, input logic [31:0] etd);
    rf_exp_t e;
    drive(wen, dest, ld, res, rdata, rs, rt);
    if (sb.size() > 0 && sb[$].ld) begin
      sb[$].wdata = rdata;
      sb[$].ld    = 1'b0;
    end
    #1;
    vec++;
    if (bus.stall !== es) begin
      errs++; $display("FAIL %s stall: got %b want %b", nm, bus.stall, es);
    end
    vec++;
    if (bus.rs_fwd !== erf || bus.rs_fwd_data !== erd) begin
      errs++;
      $display("FAIL %s rs: got fwd=%b data=%h want fwd=%b data=%h", nm, bus.rs_fwd,
               bus.rs_fwd_data, erf, erd);
    end
    vec++;
    if (bus.rt_fwd !== etf || bus.rt_fwd_data !== etd) begin
      errs++;
      $display("FAIL %s rt: got fwd=%b data=%h want fwd=%b data=%h", nm, bus.rt_fwd,
               bus.rt_fwd_data, etf, etd);
    end
    vec++;
    if (bus.stall_count !== 32'(exp_cnt)) begin
      errs++; $display("FAIL %s stall_count: got %0d want %0d", nm, bus.stall_count, exp_cnt);
    end
    sb.push_back('{we: wen && (dest != 5'd0), waddr: dest, wdata: res, ld: ld});
    @(posedge clk);
    if (es) exp_cnt++;
    #1;
    if (sb.size() == 2) begin
      e = sb.pop_front();
      vec++;
      if (bus.rf_we !== e.we || bus.rf_waddr !== e.waddr || bus.rf_wdata !== e.wdata) begin
        errs++;
        $display("FAIL %s rf_write: got we=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
                 nm, bus.rf_we, bus.rf_waddr, bus.rf_wdata, e.we, e.waddr, e.wdata);
      end
    end
  endtask

  task automatic do_reset(input int cyc);
    resetn = 1'b0;
    repeat (cyc) begin
      @(posedge clk);
      #1;
      vec++;
      if (bus.stall !== 1'b0 || bus.rs_fwd !== 1'b0 || bus.rt_fwd !== 1'b0) begin
        errs++;
        $display("FAIL in_reset answers: got stall=%b rs_fwd=%b rt_fwd=%b want 0 0 0",
                 bus.stall, bus.rs_fwd, bus.rt_fwd);
      end
      vec++;
      if (bus.rf_we !== 1'b0 || bus.stall_count !== 32'd0) begin
        errs++;
        $display("FAIL in_reset rf/count: got rf_we=%b stall_count=%0d want 0 0",
                 bus.rf_we, bus.stall_count);
      end
    end
    resetn  = 1'b1;
    exp_cnt = 0;
    sb.delete();
    sb.push_back('{we: 1'b0, waddr: 5'd0, wdata: 32'd0, ld: 1'b0});
  endtask

  task automatic test_reset();
    drive(1'b1, 5'd8, 1'b0, 32'h8888, 32'h0, 5'd8, 5'd0);
    do_reset(2);
    tick("rst_after0", 1'b0, 5'd8, 1'b0, 32'h0, 32'h0, 5'd8, 5'd0, 0, 0, 32'h0, 0, 32'h0);
    tick("rst_after1", 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd8, 5'd8, 0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic test_alu_chain();
    tick("alu_ex", 1'b1, 5'd8, 1'b0, 32'h1234, 32'h0, 5'd8, 5'd0, 0, 1, 32'h1234, 0, 32'h0);
    tick("alu_mem", 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd8, 0, 0, 32'h0, 1, 32'h1234);
    tick("alu_wb", 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd8, 5'd0, 0, 1, 32'h1234, 0, 32'h0);
  endtask

  task automatic test_load_use();
    tick("lu_ex", 1'b1, 5'd9, 1'b1, 32'hAAAA, 32'h0, 5'd0, 5'd9, 1, 0, 32'h0, 0, 32'h0);
    tick("lu_mem", 1'b0, 5'd0, 1'b0, 32'h0, 32'hDEADBEEF, 5'd0, 5'd9,
         0, 0, 32'h0, 1, 32'hDEADBEEF);
    tick("lu_wb", 1'b0, 5'd0, 1'b0, 32'h0, 32'h1111, 5'd9, 5'd0, 0, 1, 32'hDEADBEEF, 0, 32'h0);
    tick("lu_drain", 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic test_priority();
    tick("pri_wb_fill", 1'b1, 5'd10, 1'b0, 32'h3, 32'h0, 5'd0, 5'd0, 0, 0, 32'h0, 0, 32'h0);
    tick("pri_mem_fill", 1'b1, 5'd10, 1'b0, 32'h2, 32'h0, 5'd10, 5'd0, 0, 1, 32'h2, 0, 32'h0);
    drive(1'b1, 5'd10, 1'b0, 32'h1, 32'h0, 5'd10, 5'd0);
    #1;
    vec++;
    if (bus.rs_fwd !== 1'b1 || bus.rs_fwd_data !== 32'h1) begin
      errs++;
      $display("FAIL pri_ex: got fwd=%b data=%h want fwd=1 data=00000001",
               bus.rs_fwd, bus.rs_fwd_data);
    end
    tick("pri_mem", 1'b0, 5'd10, 1'b0, 32'h1, 32'h0, 5'd10, 5'd0, 0, 1, 32'h2, 0, 32'h0);
    tick("pri_wb_over_dead_mem", 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd10, 5'd0,
         0, 1, 32'h2, 0, 32'h0);
    tick("pri_refill", 1'b1, 5'd10, 1'b0, 32'h3, 32'h0, 5'd0, 5'd0, 0, 0, 32'h0, 0, 32'h0);
    tick("pri_bubble", 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 0, 0, 32'h0, 0, 32'h0);
    tick("pri_wb", 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd10, 5'd0, 0, 1, 32'h3, 0, 32'h0);
  endtask

  task automatic test_zero_reg();
    tick("z_alu", 1'b1, 5'd0, 1'b0, 32'h5, 32'h0, 5'd0, 5'd0, 0, 0, 32'h0, 0, 32'h0);
    tick("z_load", 1'b1, 5'd0, 1'b1, 32'h7, 32'h0, 5'd0, 5'd0, 0, 0, 32'h0, 0, 32'h0);
    tick("z_drain0", 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 0, 0, 32'h0, 0, 32'h0);
    tick("z_drain1", 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic test_back_to_back();
    tick("b2b0", 1'b1, 5'd5, 1'b0, 32'h11, 32'h0, 5'd0, 5'd0, 0, 0, 32'h0, 0, 32'h0);
    tick("b2b1", 1'b1, 5'd6, 1'b0, 32'h22, 32'h0, 5'd5, 5'd0, 0, 1, 32'h11, 0, 32'h0);
    tick("b2b2", 1'b1, 5'd7, 1'b0, 32'h33, 32'h0, 5'd5, 5'd6, 0, 1, 32'h11, 1, 32'h22);
    tick("b2b3", 1'b1, 5'd11, 1'b1, 32'hBAD, 32'h0, 5'd11, 5'd6, 1, 0, 32'h0, 1, 32'h22);
    tick("b2b4", 1'b0, 5'd11, 1'b0, 32'h0, 32'hCAFE0001, 5'd11, 5'd7,
         0, 1, 32'hCAFE0001, 1, 32'h33);
    tick("b2b5", 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd11, 5'd0, 0, 1, 32'hCAFE0001, 0, 32'h0);
    tick("b2b6", 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic test_reset_midflight();
    tick("mid_load", 1'b1, 5'd9, 1'b1, 32'h99, 32'h0, 5'd0, 5'd0, 0, 0, 32'h0, 0, 32'h0);
    drive(1'b1, 5'd9, 1'b1, 32'h0, 32'h5555AAAA, 5'd0, 5'd9);
    do_reset(1);
    tick("mid_after0", 1'b0, 5'd9, 1'b0, 32'h0, 32'h5555AAAA, 5'd9, 5'd9,
         0, 0, 32'h0, 0, 32'h0);
    tick("mid_after1", 1'b0, 5'd9, 1'b0, 32'h0, 32'h5555AAAA, 5'd9, 5'd9,
         0, 0, 32'h0, 0, 32'h0);
    tick("mid_after2", 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd9, 5'd9, 0, 0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    vec     = 0;
    errs    = 0;
    exp_cnt = 0;
    resetn  = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    test_reset();
    test_alu_chain();
    test_load_use();
    test_priority();
    test_zero_reg();
    test_back_to_back();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/writeback_bypass_unit.md
# writeback_bypass_unit

Tracks the destination register, write enable and result of the instructions in the EX, MEM and WB pipeline stages of the 5-stage MIPS core. It performs the single register-file write per cycle from the WB slot. It answers the decode stage's source-register queries (`forward_rs`/`forward_rt`) with bypass data or a load-use stall. It is the writer and hazard-responder counterpart of the decode stage's register reads.

## Interface
Parameters:
- `REG_W`, 5, register address width
- `DATA_W`, 32, datapath width

Ports:
- `clk`  in  1  clock, all state updates on posedge
- `resetn`  in  1  synchronous, active-low reset
- `forward_rs`  in  5  decode rs query; 0 = no source
- `forward_rt`  in  5  decode rt query; 0 = no source
- `ex_wen`  in  1  instruction in EX writes a register (decode registered `de_wen`)
- `ex_dest`  in  5  EX destination (decode registered `de_regsrc`)
- `ex_is_load`  in  1  EX instruction is LW
- `ex_result`  in  32  ALU result of EX instruction
- `mem_rdata`  in  32  data RAM read data for the instruction currently in MEM
- `stall`  out  1  load-use stall request to fetch/decode
- `rs_fwd`  out  1  `rs_fwd_data` replaces register-file `rdata1`
- `rs_fwd_data`  out  32  bypass value for rs
- `rt_fwd`  out  1  `rt_fwd_data` replaces register-file `rdata2`
- `rt_fwd_data`  out  32  bypass value for rt
- `rf_we`  out  1  register-file write enable
- `rf_waddr`  out  5  register-file write address
- `rf_wdata`  out  32  register-file write data
- `stall_count`  out  32  cycles with `stall`=1 since reset, wraps

## Operation
- Two internal slots, each holding {wen, dest, is_load, value}:
  - MEM slot ← {ex_wen, ex_dest, ex_is_load, ex_result} every cycle.
  - WB slot ← {mem.wen, mem.dest, mem.is_load ? mem_rdata : mem.value} every cycle.
- There is no enable on the shift. The decode stage inserts bubbles by deasserting `de_wen` when it sees `stall`.
- Register-file write, registered from the WB slot:
  - `rf_we` = wb.wen & (wb.dest != 0)
  - `rf_waddr` = wb.dest
  - `rf_wdata` = wb.value
- Hit rule for a query q: q != 0 and slot.wen and slot.dest == q. Register $0 is never forwarded or written.
- Bypass priority per query is EX > MEM > WB. The youngest writer wins.
  - EX hit, not a load: data = `ex_result`.
  - EX hit, load: no data. Raise `stall` instead.
  - MEM hit: data = mem.is_load ? `mem_rdata` : mem.value.
  - WB hit: data = wb.value. This covers a read in the same cycle as the write, because the register file has no write-through.
- `stall` = (EX hit on `forward_rs` or `forward_rt`) & `ex_is_load`.
- If the EX stage hits as a load, lower-priority slots are ignored for that query: `*_fwd`=0 and `stall`=1.
- `*_fwd_data` = 0 when `*_fwd`=0.
- `stall_count` increments on every posedge with `stall`=1 and `resetn`=1.

## Timing
- `stall`, `rs_fwd`/`rt_fwd` and their data are combinational from the inputs and slot state in the same cycle. All are forced to 0 while `resetn`=0, because decode outputs are unreset.
- Result path: EX at cycle n → MEM slot at n+1 → WB slot at n+2. `rf_we`/`rf_waddr`/`rf_wdata` are valid during cycle n+2.
- Load-use:
  - Cycle n: `stall`=1 for exactly one cycle.
  - Cycle n+1: the load is in MEM and the bubble is in EX. The dependent instruction is bypassed from `mem_rdata` with `stall`=0.
- Reset, at a posedge with `resetn`=0:
  - Both slots are cleared to {0,0,0,0}.
  - `stall_count` is set to 0.
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0.
  - An in-flight load or ALU result is discarded and never written.
- Simultaneous write and query of the same register in WB: the bypass returns the new value, and the register file is written in the same cycle.

## Test plan
- Reset: hold `resetn`=0 for 2 cycles with `ex_wen`=1, `ex_dest`=8, `forward_rs`=8 → `stall`=0, `rs_fwd`=0, `rf_we`=0, `stall_count`=0 during reset and in the first cycle after it.
- ALU chain: EX add with dest 8, result 0x00001234, `forward_rs`=8 → `rs_fwd`=1, data 0x00001234, `stall`=0. Two cycles later, `rf_we`=1, `rf_waddr`=8, `rf_wdata`=0x00001234.
- Load-use: EX lw with dest 9, `forward_rt`=9 → `stall`=1. Next cycle `ex_wen`=0, `mem_rdata`=0xDEADBEEF → `rt_fwd`=1, data 0xDEADBEEF, `stall`=0, `stall_count`=1. WB write of 0xDEADBEEF to r9 follows one cycle later.
- Priority: r10 is in flight with values 0x1 (EX), 0x2 (MEM) and 0x3 (WB), `forward_rs`=10 → data 0x1. With `ex_wen`=0 → data 0x2. With only the WB slot holding r10 → data 0x3.
- $0: EX has `ex_wen`=1, dest 0, result 5, with `forward_rs`=0 and `forward_rt`=0 → no fwd and no stall. Two cycles later `rf_we`=0.
- Reset mid-flight: a load is in MEM and `resetn` is pulsed low for one cycle → `rf_we` stays 0 and no bypass hits on r9 afterward.
